// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: oversampling tick and serial line in, parallel
// byte with done strobe and framing-error flag out.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic                 i_tick;
    logic                 i_rx;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_rx_done;
    logic                 o_frame_err;

    modport master (
        output i_tick, i_rx,
        input  o_data, o_rx_done, o_frame_err
    );

    modport slave (
        input  i_tick, i_rx,
        output o_data, o_rx_done, o_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: oversampled start/data/stop FSM with mid-bit sampling,
// 2-flop input synchroniser and registered done/frame-error outputs.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned SB_TICKS   = 16,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CNT_BITS   = 4
) (
    input  logic     i_clk,
    input  logic     i_reset,
    uart_rx_if.slave rx_if
);
    localparam int unsigned N_BITS = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_BITS-1:0] HALF_LAST = CNT_BITS'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_BITS-1:0] BIT_LAST  = CNT_BITS'(OVERSAMPLE - 1);
    localparam logic [CNT_BITS-1:0] STOP_LAST = CNT_BITS'(SB_TICKS - 1);
    localparam logic [N_BITS-1:0]   N_LAST    = N_BITS'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_next;
    logic [CNT_BITS-1:0]  s, s_next;
    logic [N_BITS-1:0]    n, n_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [DATA_BITS-1:0] data, data_next;
    logic                 done, done_next;
    logic                 ferr, ferr_next;
    logic [1:0]           sync;
    logic                 rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            shreg <= '0;
            data  <= '0;
            done  <= 1'b0;
            ferr  <= 1'b0;
            sync  <= '1;
        end else begin
            state <= state_next;
            s     <= s_next;
            n     <= n_next;
            shreg <= shreg_next;
            data  <= data_next;
            done  <= done_next;
            ferr  <= ferr_next;
            sync  <= {sync[0], rx_if.i_rx};
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        shreg_next = shreg;
        data_next  = data;
        ferr_next  = ferr;
        done_next  = 1'b0;
        unique case (state)
            // Start detection is the only transition not gated by the tick.
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (rx_if.i_tick) begin
                    if (s == HALF_LAST) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + CNT_BITS'(1);
                    end
                end
            end
            DATA: begin
                if (rx_if.i_tick) begin
                    if (s == BIT_LAST) begin
                        shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
                        s_next     = '0;
                        if (n == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n + N_BITS'(1);
                        end
                    end else begin
                        s_next = s + CNT_BITS'(1);
                    end
                end
            end
            STOP: begin
                if (rx_if.i_tick) begin
                    if (s == STOP_LAST) begin
                        state_next = IDLE;
                        data_next  = shreg;
                        ferr_next  = ~rx_s;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s + CNT_BITS'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_if.o_data      = data;
    assign rx_if.o_rx_done   = done;
    assign rx_if.o_frame_err = ferr;
endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frames are driven tick-aligned on the line and
// every done strobe is matched against a queue of frames the bench sent.
module tb_uart_rx;
    localparam int unsigned LATENCY = 16 / 2 + 16 * 8 + 16;

    typedef struct {
        logic [7:0]  data;
        logic        ferr;
        int unsigned start;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned div = 0;
    int unsigned tick_total = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_done = 0;
    logic prev_done = 1'b0;
    logic [7:0] last_data = 8'h00;
    frame_t exp_q[$];

    uart_rx_if #(.DATA_BITS(8)) rx_if ();

    uart_rx #(
        .DATA_BITS (8),
        .SB_TICKS  (16),
        .OVERSAMPLE(16),
        .CNT_BITS  (4)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .rx_if  (rx_if)
    );

    always #5 clk = ~clk;

    // Baud-tick source equivalent to a divider with max count 15.
    assign rx_if.i_tick = (div == 15);
    always @(posedge clk) begin
        div <= (div == 15) ? 0 : div + 1;
        if (rx_if.i_tick) tick_total <= tick_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_if.o_rx_done) begin
            n_done++;
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", {24'd0, rx_if.o_data}, 32'hFFFF_FFFF);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                check("data", {24'd0, rx_if.o_data}, {24'd0, f.data});
                check("frame_err", {31'd0, rx_if.o_frame_err}, {31'd0, f.ferr});
                check("latency", tick_total - f.start, LATENCY);
                last_data = f.data;
            end
        end
        prev_done = rx_if.o_rx_done;
    end

    task automatic wait_ticks(input int unsigned k);
        int unsigned t;
        for (int unsigned i = 0; i < k; i++) begin
            t = tick_total;
            while (tick_total == t) @(negedge clk);
        end
    endtask

    // A bad stop bit is held low only through its mid-bit sample, so the line is
    // high again by the time a re-armed start check would look at it.
    task automatic send_frame(input logic [7:0] b, input logic good_stop);
        frame_t f;
        wait_ticks(1);
        f.data  = b;
        f.ferr  = ~good_stop;
        f.start = tick_total;
        exp_q.push_back(f);
        rx_if.i_rx = 1'b0;
        wait_ticks(16);
        for (int unsigned i = 0; i < 8; i++) begin
            rx_if.i_rx = b[i];
            wait_ticks(16);
        end
        if (good_stop) begin
            rx_if.i_rx = 1'b1;
            wait_ticks(16);
        end else begin
            rx_if.i_rx = 1'b0;
            wait_ticks(12);
            rx_if.i_rx = 1'b1;
            wait_ticks(4);
        end
    endtask

    task automatic drain(input string tag);
        int unsigned budget = 200;
        while (exp_q.size() != 0 && budget != 0) begin
            wait_ticks(1);
            budget--;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] b81;
        int unsigned done_before;
        rst_n = 1'b0;
        rx_if.i_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, rx_if.o_data}, 32'd0);
        check("rst_done", {31'd0, rx_if.o_rx_done}, 32'd0);
        check("rst_ferr", {31'd0, rx_if.o_frame_err}, 32'd0);
        rst_n = 1'b1;
        wait_ticks(500);
        check("idle_no_done", n_done, 0);
        check("idle_data", {24'd0, rx_if.o_data}, 32'd0);

        send_frame(8'hA5, 1'b1);
        drain("drain_a5");

        // Glitch: 4 ticks low, then a real frame starting 4 ticks later.
        wait_ticks(1);
        done_before = n_done;
        rx_if.i_rx = 1'b0;
        wait_ticks(4);
        rx_if.i_rx = 1'b1;
        wait_ticks(3);
        check("glitch_no_done", n_done - done_before, 0);
        check("glitch_hold", {24'd0, rx_if.o_data}, {24'd0, last_data});
        send_frame(8'h17, 1'b1);
        drain("drain_glitch");

        send_frame(8'h3C, 1'b0);
        wait_ticks(20);
        send_frame(8'h5A, 1'b1);
        drain("drain_ferr");

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drain("drain_b2b");

        for (int unsigned i = 0; i < 8; i++) begin
            logic [7:0] rb;
            logic good;
            wait_ticks($urandom_range(0, 10));
            rb = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send_frame(rb, good);
        end
        drain("drain_rand");

        // Reset during data bit 3 of 0x81.
        b81 = 8'h81;
        done_before = n_done;
        wait_ticks(1);
        rx_if.i_rx = 1'b0;
        wait_ticks(16);
        for (int unsigned i = 0; i < 3; i++) begin
            rx_if.i_rx = b81[i];
            wait_ticks(16);
        end
        rx_if.i_rx = b81[3];
        wait_ticks(8);
        rst_n = 1'b0;
        rx_if.i_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_done", {31'd0, rx_if.o_rx_done}, 32'd0);
        check("midrst_data", {24'd0, rx_if.o_data}, 32'd0);
        rst_n = 1'b1;
        last_data = 8'h00;
        wait_ticks(200);
        check("midrst_no_done", n_done - done_before, 0);
        check("midrst_hold", {24'd0, rx_if.o_data}, 32'd0);
        send_frame(8'h42, 1'b1);
        drain("drain_42");
        check("final_data", {24'd0, rx_if.o_data}, 32'h42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that consumes the oversampling tick from baudrate_generator, at 16 ticks per bit period.
- Deserialises an asynchronous, LSB-first 8N1 serial line into parallel bytes.
- Presents each received byte with a one-clock done strobe and a framing-error flag to the downstream interface/ALU control logic.

Parameters:
- DATA_BITS, default 8: data bits per frame.
- SB_TICKS, default 16: ticks spent in the stop state. 16 means one stop bit.
- OVERSAMPLE, default 16: ticks per bit period. It must equal the baudrate_generator oversampling ratio.
- CNT_BITS, default 4: width of the tick counter. Requires 2^CNT_BITS >= max(OVERSAMPLE, SB_TICKS).

Ports:
- i_clk, input, 1: system clock. All state changes on its rising edge.
- i_reset, input, 1: asynchronous, active-low reset.
- i_tick, input, 1: one-clock pulse from baudrate_generator o_tick.
- i_rx, input, 1: serial line. Asynchronous; idle level is high.
- o_data, output, DATA_BITS: last received byte.
- o_rx_done, output, 1: one-clock pulse when o_data is updated.
- o_frame_err, output, 1: stop bit sampled low on the last frame.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE; tick counter s=0; bit counter n=0; shift register=0.
  - o_data=0, o_rx_done=0, o_frame_err=0.
  - Both i_rx synchroniser flops are set to 1 (idle).
  - Release is synchronous to the next i_clk edge.
- i_rx passes through a 2-flop synchroniser, giving rx_s. All decisions use rx_s, which adds 2 clocks of latency.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - rx_s==0 -> START, s=0. This transition does not depend on i_tick.
- START, on each i_tick:
  - If s==OVERSAMPLE/2-1 and rx_s==0 -> DATA, s=0, n=0.
  - If s==OVERSAMPLE/2-1 and rx_s==1 -> IDLE. This rejects a glitch; no done, no error.
  - Otherwise s++.
- DATA, on each i_tick:
  - If s==OVERSAMPLE-1: shift register = {rx_s, shreg[DATA_BITS-1:1]} (LSB first), s=0.
    - If n==DATA_BITS-1 -> STOP; otherwise n++.
  - Otherwise s++.
  - Each sample is therefore taken at mid-bit.
- STOP, on each i_tick:
  - If s==SB_TICKS-1 -> IDLE. On the same edge: o_data = shift register, o_frame_err = ~rx_s, o_rx_done = 1.
  - Otherwise s++.
- Without i_tick, state and counters hold in every state except the IDLE->START transition.
- o_rx_done:
  - Registered. High for exactly one i_clk cycle, following the edge that completes STOP.
  - Deasserted on the next edge, whether or not a tick occurs.
- o_data and o_frame_err:
  - Update only on the done edge. Hold between frames.
  - A frame with a framing error still updates o_data and pulses o_rx_done.
- Frame latency: about 8 + 16*DATA_BITS + SB_TICKS ticks after the synchronised falling edge of the start bit. This is 152 ticks for the defaults.
- Back-to-back frames:
  - Return to IDLE happens at mid-stop-bit, so a start bit immediately following the stop bit is detected with no lost frame.
- Line held low:
  - After a done with o_frame_err=1, IDLE sees rx_s==0 and re-enters START.
  - Each 16-tick-wide low period is treated as a new frame. A break condition therefore yields repeated 0x00 frames with frame_err=1.
- Reset mid-frame:
  - Aborts immediately and leaves o_rx_done=0.
  - No partial byte appears on o_data.
- Counter widths never overflow; s wraps only through explicit clears.

Test Plan:
- Reset: hold i_reset=0 for 3 clocks with i_rx=1. Then o_data=0x00, o_rx_done=0, o_frame_err=0, FSM idle, and no done for 500 ticks.
- Single frame: baudrate_generator with BAUDRATE_MAX_COUNT=15 drives i_tick; send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at 16 ticks/bit. Required: one o_rx_done pulse lasting exactly 1 clock, o_data=0xA5, o_frame_err=0, done about 152 ticks after the start edge.
- Glitch rejection: pulse i_rx low for 4 ticks, then high. Required: no o_rx_done, o_data unchanged, FSM back in IDLE before tick 8.
- Framing error: send 0x3C with the stop bit driven 0, then line high. Required: o_rx_done pulse, o_data=0x3C, o_frame_err=1. A following good frame 0x5A clears o_frame_err to 0.
- Back-to-back: send 0x00 then 0xFF with no idle gap. Required: two done pulses about 160 ticks apart, o_data=0x00 then 0xFF, both with frame_err=0.
- Reset mid-frame: assert i_reset=0 during data bit 3 of 0x81, then release and send 0x42. Required: no done for 0x81, o_data=0x00 after reset, then o_data=0x42 with one done pulse.
